// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with a sequential clear sweep after reset or on request.
// Define RAM_SYNC_CLR_INV_OUT_EN to present dout inverted (inverted-output RAM-chip behaviour).
module ram_sync_clr #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // A clear request in IDLE takes priority over any access on the same edge
    logic access_c;
    assign access_c = (state == ST_IDLE) && !clr && !cs_n;

    // Control FSM: clear sweep, read register and read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    rd_valid_q <= 1'b0;
                    clr_ptr    <= clr_ptr + ADDR_W'(1);
                    if (&clr_ptr) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state      <= ST_CLEAR;
                        rd_valid_q <= 1'b0;
                    end else if (!cs_n && we_n) begin
                        rd_q       <= mem[addr];
                        rd_valid_q <= 1'b1;
                    end else begin
                        rd_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_CLEAR;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array has no reset; it is zeroed only by the sweep
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (access_c && !we_n) begin
            mem[addr] <= din;
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign rd_valid = rd_valid_q;

`ifdef RAM_SYNC_CLR_INV_OUT_EN
    assign dout = ~rd_q;
`else
    assign dout = rd_q;
`endif

endmodule

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the data word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the address width; the number of words is DEPTH = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cs_n  input  1  chip select, active low.
REQ-006 SHALL have port we_n  input  1  write enable, active low; qualified by cs_n.
REQ-007 SHALL have port addr  input  ADDR_W  word address.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port clr  input  1  synchronous request to zero the whole array.
REQ-010 SHALL have port dout  output  DATA_W  registered read data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle strobe: dout was updated by a read.
REQ-012 SHALL have port busy  output  1  high while the array is being cleared; all accesses are ignored.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-014 In CLEAR, each rising edge SHALL write zero to mem[clr_ptr] and then increment clr_ptr, which is ADDR_W bits wide and starts at 0.
REQ-015 The edge that clears address DEPTH-1 SHALL move the FSM to IDLE and SHALL wrap clr_ptr to 0.
REQ-016 busy SHALL equal (state == CLEAR), decoded from the state register with no combinational path from inputs.
REQ-017 In IDLE with clr=1 at an edge, the FSM SHALL enter CLEAR and any simultaneous cs_n/we_n access SHALL be dropped (clr wins).
REQ-018 In IDLE with cs_n=0 and we_n=0, the edge SHALL write mem[addr] <= din; dout SHALL hold; rd_valid SHALL be 0 next cycle.
REQ-019 In IDLE with cs_n=0 and we_n=1, the edge SHALL load the read register with mem[addr] and assert rd_valid for exactly the following cycle. Read latency is 1 clock.
REQ-020 With cs_n=1, or in CLEAR, the array, the read register and dout SHALL hold, and rd_valid SHALL be 0.
REQ-021 A read SHALL return the value of the most recent completed write to that address, or zero if the address has been cleared since.
REQ-022 Back-to-back reads on consecutive cycles SHALL each produce a rd_valid pulse, so rd_valid stays high continuously.
REQ-023 clr asserted while in CLEAR SHALL be ignored; the sweep does not restart.
REQ-024 The array SHALL NOT be reset directly; it is zeroed only by the CLEAR sweep.

Reset
REQ-025 While rst_n=0, the following SHALL hold: state=CLEAR, clr_ptr=0, read register=0, rd_valid=0, busy=1.
REQ-026 After rst_n rises, busy SHALL remain high for exactly DEPTH rising edges (16 at default parameters), then fall.
REQ-027 rst_n asserted mid-sweep or mid-access SHALL abort the operation; the sweep SHALL restart from address 0 after release.

Configuration
REQ-028 Macro RAM_SYNC_CLR_INV_OUT_EN SHALL select the output polarity.
REQ-029 With RAM_SYNC_CLR_INV_OUT_EN defined, dout SHALL equal the bitwise inverse of the read register (inverted-output RAM-chip behaviour), so dout resets to all ones.
REQ-030 Without RAM_SYNC_CLR_INV_OUT_EN, dout SHALL equal the read register, so dout resets to zero.
REQ-031 The macro SHALL affect no timing, no other output, and no array contents.

Verification (DATA_W=4, ADDR_W=4)
REQ-032 Release rst_n, then count edges -> busy is high for exactly 16 edges; reading addresses 0..15 afterwards returns 0x0 each, with rd_valid=1 one cycle after each request.
REQ-033 Write 0xA to address 3, then read address 3 on the next cycle -> dout=0xA and rd_valid=1 one cycle after the read; with the macro defined, dout=0x5.
REQ-034 Write 0x7 to address 5, pulse clr with a simultaneous write of 0xF to address 6, wait for busy to fall, then read addresses 5 and 6 -> both return 0x0.
REQ-035 Assert rst_n low during the sweep at clr_ptr=8, then release -> busy is high for 16 more edges and dout returns to its reset value.
REQ-036 Attempt a write with cs_n=1 (0xC to address 2), then a write during busy -> a read of address 2 returns the prior value, and rd_valid stays 0 during busy.
REQ-037 Issue reads of addresses 0, 1 and 2 back-to-back after writing 0x1, 0x2 and 0x3 -> rd_valid is high for 3 consecutive cycles with dout = 0x1, 0x2, 0x3.
